pow2_accum: RTL
===============

# pow2_accum

Downstream consumer of the pow2 stage. Accepts a length command N, then pulls exactly N results from pow2's valid/yumi output and sums them modulo 2^width_p with a sticky overflow flag. Presents the sum to the next stage on a valid/ready handshake, then returns to idle for the next command.

## Interface

Parameters:
- width_p, default 32: data and sum width; matches the pow2 data_o width.
- len_width_p, default 8: width of the length command; N ranges 0..2^len_width_p-1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- len_i  in  len_width_p  number of pow2 results to accumulate.
- len_v_i  in  1  len_i is valid.
- len_ready_o  out  1  block is idle and accepts a command.
- data_i  in  width_p  pow2 result (connects to pow2 data_o).
- v_i  in  1  data_i is valid (connects to pow2 v_o).
- yumi_o  out  1  data_i consumed this cycle (connects to pow2 yumi_i).
- sum_o  out  width_p  accumulated sum.
- overflow_o  out  1  at least one addition in this run carried out of width_p.
- v_o  out  1  sum_o and overflow_o are valid.
- ready_i  in  1  downstream accepts sum_o.

## Operation

- States: eIDLE, eACCUM, eDONE.
- Output decode:
  - len_ready_o = (state == eIDLE).
  - v_o = (state == eDONE).
  - yumi_o = (state == eACCUM) & v_i, combinational from v_i. yumi_o is never asserted while v_i is low.
- eIDLE, on len_v_i & len_ready_o:
  - sum_r <= 0, ovf_r <= 0, rem_r <= len_i.
  - If len_i == 0: go to eDONE.
  - Otherwise: go to eACCUM.
- eACCUM, on yumi_o:
  - {carry, sum_r} <= sum_r + data_i; the sum wraps mod 2^width_p.
  - ovf_r <= ovf_r | carry.
  - rem_r <= rem_r - 1.
  - If rem_r == 1: go to eDONE.
- eACCUM with v_i low: hold all state.
- eDONE: hold sum_r and ovf_r. On ready_i, go to eIDLE.
- sum_o = sum_r and overflow_o = ovf_r in every state. Their values are meaningful only while v_o is high.
- data_i and v_i are ignored in eIDLE and eDONE. Nothing is consumed in those states, so pow2 holds its result.
- len_v_i is ignored outside eIDLE. The command is not latched.

## Timing

- Reset (reset_n_i low, asynchronous, takes effect immediately without waiting for an edge):
  - state = eIDLE, sum_r = 0, ovf_r = 0, rem_r = 0.
  - Resulting outputs: len_ready_o = 1, yumi_o = 0, v_o = 0, sum_o = 0, overflow_o = 0.
- Reset release: the first state update happens at the first rising edge with reset_n_i high.
- Reset mid-run (eACCUM or eDONE): the run is abandoned with no partial output. A pow2 result presented in that cycle is not consumed.
- Command accept: accepted in the cycle where len_v_i & len_ready_o; len_ready_o drops the next cycle.
- Earliest data consume: the cycle after command accept.
- Throughput: one result per cycle while v_i stays high. pow2 itself delivers at most one result per (exp+2) cycles.
- Latency, N > 0: v_o rises in the cycle after the Nth yumi_o.
- Latency, N == 0: v_o rises the cycle after command accept; sum_o = 0, overflow_o = 0.
- Output handshake:
  - Transfer occurs in a cycle with v_o & ready_i.
  - len_ready_o rises the next cycle; a back-to-back command is accepted at the earliest one cycle after the transfer.
  - v_o held with ready_i low: sum_o and overflow_o remain stable.
- Overflow: sticky for the run; cleared only by a new command or by reset.
- Length boundary: N = 2^len_width_p-1 must be supported. rem_r never decrements in eIDLE or eDONE, so it cannot wrap.

## Test plan

- Reset behaviour: assert reset_n_i low mid-eACCUM (after 2 of 4 results) -> outputs immediately return to reset values. A fresh command N=1 with data 8 -> sum_o=8.
- Basic run: N=3 with pow2 exps 0, 3, 5 -> exactly 3 yumi_o pulses; v_o with sum_o=41, overflow_o=0.
- Zero length: N=0 -> v_o the next cycle, sum_o=0, overflow_o=0, no yumi_o ever asserted. An unsolicited v_i in that window stays unconsumed.
- Overflow: width_p=32, N=2, data 0x80000000 twice -> sum_o=0, overflow_o=1. The next run with N=1, data 4 -> sum_o=4, overflow_o=0.
- Backpressure: hold ready_i=0 for 10 cycles in eDONE -> v_o, sum_o and overflow_o stable, len_ready_o=0, len_v_i ignored. Raise ready_i -> len_ready_o=1 the following cycle.
- Stalled input: v_i toggling randomly during a run with N=5 -> yumi_o only when v_i=1; the sum equals the reference sum of the 5 consumed values.

Source files
------------

// File: rtl/pow2_accum.sv
// pow2_accum: sums N pow2 results (mod 2^width_p) with sticky overflow, then
// presents the sum on a valid/ready handshake.
// Ports:
//   clk_i, reset_n_i           clock, async active-low reset
//   len_i, len_v_i, len_ready_o  length command in (accepted while idle)
//   data_i, v_i, yumi_o        pow2 result stream in (valid/yumi)
//   sum_o, overflow_o, v_o, ready_i  result out (valid/ready)
module pow2_accum #(
  parameter int width_p     = 32,
  parameter int len_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [len_width_p-1:0] len_i,
  input  logic                   len_v_i,
  output logic                   len_ready_o,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  output logic                   yumi_o,
  output logic [width_p-1:0]     sum_o,
  output logic                   overflow_o,
  output logic                   v_o,
  input  logic                   ready_i
);
  typedef enum logic [1:0] {eIDLE, eACCUM, eDONE} state_e;
  state_e                 r_state, w_next;
  logic [width_p-1:0]     r_sum;
  logic                   r_ovf;
  logic [len_width_p-1:0] r_rem;
  logic [width_p:0]       w_add;
  logic                   w_start;
  // the extra MSB of w_add is the carry out of width_p
  assign w_add   = {1'b0, r_sum} + {1'b0, data_i};
  assign w_start = len_v_i & len_ready_o;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_state <= eIDLE;
    else            r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      eIDLE:   if (w_start) w_next = (len_i == '0) ? eDONE : eACCUM;
      eACCUM:  if (yumi_o && r_rem == len_width_p'(1)) w_next = eDONE;
      eDONE:   if (ready_i) w_next = eIDLE;
      default: w_next = eIDLE;
    endcase
  end
  always_comb begin
    len_ready_o = (r_state == eIDLE);
    v_o         = (r_state == eDONE);
    yumi_o      = (r_state == eACCUM) & v_i;
    sum_o       = r_sum;
    overflow_o  = r_ovf;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
      r_rem <= '0;
    end else if (w_start) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
      r_rem <= len_i;
    end else if (yumi_o) begin
      r_sum <= w_add[width_p-1:0];
      r_ovf <= r_ovf | w_add[width_p];
      r_rem <= r_rem - len_width_p'(1);
    end
endmodule
